// File: rtl/rx_data_monitor_if.sv
// Register bus between the RX monitor (master) and the UART register block (slave).
interface rx_data_monitor_if;
  logic [1:0] Addr;
  logic [7:0] DataIn;
  logic       CS_N;
  logic       RD_N;
  logic       WR_N;

  modport master (
    output Addr,
    output CS_N,
    output RD_N,
    output WR_N,
    input  DataIn
  );

  modport slave (
    input  Addr,
    input  CS_N,
    input  RD_N,
    input  WR_N,
    output DataIn
  );
endinterface

// File: rtl/rx_data_monitor.sv
// Polls the UART status register, reads received bytes and scrolls them across
// an 8-digit active-low 7-segment display, two hex digits per byte.
module rx_data_monitor #(
  parameter int         POLL_GAP    = 4,
  parameter int         RD_WAIT     = 1,
  parameter logic [1:0] ADDR_STATUS = 2'b01,
  parameter logic [1:0] ADDR_DATA   = 2'b00,
  parameter int         RDY_BIT     = 0,
  parameter int         OVR_BIT     = 1
) (
  input  logic              SysClk,
  input  logic              Reset,
  rx_data_monitor_if.master bus,
  output logic [6:0]        HEX7,
  output logic [6:0]        HEX6,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX0,
  output logic [7:0]        RxCount,
  output logic [7:0]        ErrCount,
  output logic              RxValid
);

  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int WAIT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT);

  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STAT_RD = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_DATA_RD = 3'd3;
  localparam logic [2:0] ST_UPDATE  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              gap_done;
  logic              rd_done;
  logic              in_read;
  logic              next_is_read;
  logic              stat_rdy;
  logic              stat_ovr;
  logic [7:0]        rx_byte;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

  assign gap_done     = (gap_cnt == GAP_LAST);
  assign rd_done      = (wait_cnt == WAIT_LAST);
  assign in_read      = (state == ST_STAT_RD) || (state == ST_DATA_RD);
  assign next_is_read = (state_next == ST_STAT_RD) || (state_next == ST_DATA_RD);

  // This block only ever reads, so the write strobe is tied inactive.
  assign bus.WR_N = 1'b1;

  // Next-state decode; every read is followed by CHECK or UPDATE, never another read.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (gap_done) state_next = ST_STAT_RD;
      end
      ST_STAT_RD: begin
        if (rd_done) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        state_next = stat_rdy ? ST_DATA_RD : ST_IDLE;
      end
      ST_DATA_RD: begin
        if (rd_done) state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Idle gap counter: counts while idle and restarts whenever a poll is launched.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      gap_cnt <= '0;
    end else if ((state == ST_IDLE) && !gap_done) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // Read hold counter: stretches each strobe so slow register blocks can settle.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (in_read && !rd_done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Bus strobes are registered from the next state so they line up exactly with the read states.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      bus.CS_N <= 1'b1;
      bus.RD_N <= 1'b1;
      bus.Addr <= ADDR_STATUS;
    end else begin
      bus.CS_N <= !next_is_read;
      bus.RD_N <= !next_is_read;
      if (state_next == ST_STAT_RD) begin
        bus.Addr <= ADDR_STATUS;
      end else if (state_next == ST_DATA_RD) begin
        bus.Addr <= ADDR_DATA;
      end
    end
  end

  // Capture the status flags and the data byte only on the last cycle of each read.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      stat_rdy <= 1'b0;
      stat_ovr <= 1'b0;
      rx_byte  <= 8'h00;
    end else if (rd_done) begin
      if (state == ST_STAT_RD) begin
        stat_rdy <= bus.DataIn[RDY_BIT];
        stat_ovr <= bus.DataIn[OVR_BIT];
      end
      if (state == ST_DATA_RD) begin
        rx_byte <= bus.DataIn;
      end
    end
  end

  // Overrun counter sticks at FF so a flood of overruns is still visible.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      ErrCount <= 8'h00;
    end else if ((state == ST_CHECK) && stat_ovr && (ErrCount != 8'hFF)) begin
      ErrCount <= ErrCount + 8'h01;
    end
  end

  // Scroll the display left by one byte and show the new byte in the two rightmost digits.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      HEX7 <= SEG_DASH;
      HEX6 <= SEG_DASH;
      HEX5 <= SEG_DASH;
      HEX4 <= SEG_DASH;
      HEX3 <= SEG_DASH;
      HEX2 <= SEG_DASH;
      HEX1 <= SEG_DASH;
      HEX0 <= SEG_DASH;
    end else if (state == ST_UPDATE) begin
      HEX7 <= HEX5;
      HEX6 <= HEX4;
      HEX5 <= HEX3;
      HEX4 <= HEX2;
      HEX3 <= HEX1;
      HEX2 <= HEX0;
      HEX1 <= seg(rx_byte[7:4]);
      HEX0 <= seg(rx_byte[3:0]);
    end
  end

  // Received byte counter wraps naturally at 256.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      RxCount <= 8'h00;
    end else if (state == ST_UPDATE) begin
      RxCount <= RxCount + 8'h01;
    end
  end

  // Valid pulse appears in the cycle the new digits become visible.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      RxValid <= 1'b0;
    end else begin
      RxValid <= (state == ST_UPDATE);
    end
  end

endmodule
